// File: rtl/lcd_sequencer.sv
// Character-LCD write sequencer: buffers command/data bytes and plays each one
// onto the LCD bus with setup, enable-pulse, hold and post-write delay phases.
module lcd_sequencer #(
  parameter int SETUP_CYC       = 2,
  parameter int PULSE_CYC       = 12,
  parameter int HOLD_CYC        = 2,
  parameter int CMD_DELAY_CYC   = 2000,
  parameter int CLEAR_DELAY_CYC = 80000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  logic        i_req_rs,
  input  logic [7:0]  i_req_data,
  input  logic        i_lcd_on,
  output logic [31:0] o_io_lcd,
  output logic        o_busy,
  output logic        o_done
);

  // state  | meaning
  // IDLE   | waiting for a buffered byte
  // SETUP  | RS/DATA driven, EN low
  // PULSE  | EN high
  // HOLD   | EN low, RS/DATA still held
  // WAIT   | post-write delay for the LCD controller
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } state_t;

  localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_B   = (HOLD_CYC > CMD_DELAY_CYC) ? HOLD_CYC : CMD_DELAY_CYC;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_DLY = (MAX_C > CLEAR_DELAY_CYC) ? MAX_C : CLEAR_DELAY_CYC;
  localparam int CNT_W   = $clog2(MAX_DLY + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_DELAY_CYC - 1);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [8:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nx;
  logic             rdy_q;
  logic             push, pop;
  logic [8:0]       head;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             en_q, en_nx;
  logic             rs_q, rs_nx;
  logic [7:0]       data_q, data_nx;
  logic             done_q, done_nx;
  logic             on_q;
  logic             is_clear;
  logic             cnt_zero;

  assign push     = i_req_vld && rdy_q;
  assign head     = mem[rd_ptr];
  assign cnt_zero = (cnt == '0);
  assign is_clear = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));

  always_comb begin
    count_nx = count;
    case ({push, pop})
      2'b10:   count_nx = count + (AW+1)'(1);
      2'b01:   count_nx = count - (AW+1)'(1);
      default: count_nx = count;
    endcase
  end

  // Storage needs no reset; occupancy alone defines what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_req_rs, i_req_data};
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nx;
      rdy_q <= (count_nx != FULL_CNT);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    en_nx    = en_q;
    rs_nx    = rs_q;
    data_nx  = data_q;
    done_nx  = 1'b0;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          rs_nx    = head[8];
          data_nx  = head[7:0];
          cnt_nx   = SETUP_LD;
          state_nx = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          en_nx    = 1'b1;
          cnt_nx   = PULSE_LD;
          state_nx = ST_PULSE;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          en_nx    = 1'b0;
          cnt_nx   = HOLD_LD;
          state_nx = ST_HOLD;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          cnt_nx   = is_clear ? CLEAR_LD : CMD_LD;
          state_nx = ST_WAIT;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          done_nx  = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      en_q   <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= '0;
      done_q <= 1'b0;
      on_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      en_q   <= en_nx;
      rs_q   <= rs_nx;
      data_q <= data_nx;
      done_q <= done_nx;
      on_q   <= i_lcd_on;
    end
  end

  assign o_io_lcd  = {on_q, 20'b0, en_q, rs_q, 1'b0, data_q};
  assign o_req_rdy = rdy_q;
  assign o_busy    = (count != '0) || (state != ST_IDLE);
  assign o_done    = done_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with a byte scoreboard checked at each EN pulse.
module tb_lcd_sequencer;
  localparam int S  = 2;
  localparam int P  = 3;
  localparam int H  = 1;
  localparam int CD = 5;
  localparam int LD = 20;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } item_t;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req_vld;
  logic        o_req_rdy;
  logic        i_req_rs;
  logic [7:0]  i_req_data;
  logic        i_lcd_on;
  logic [31:0] o_io_lcd;
  logic        o_busy;
  logic        o_done;

  int    checks   = 0;
  int    failures = 0;
  item_t sb[$];

  lcd_sequencer #(
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H),
    .CMD_DELAY_CYC(CD), .CLEAR_DELAY_CYC(LD), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy),
    .i_req_rs(i_req_rs), .i_req_data(i_req_data), .i_lcd_on(i_lcd_on),
    .o_io_lcd(o_io_lcd), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Returns one time unit after the accepting edge.
  task automatic send(input logic rs, input logic [7:0] d);
    int n;
    n = 0;
    i_req_vld  = 1'b1;
    i_req_rs   = rs;
    i_req_data = d;
    while (!o_req_rdy && n < 300) begin
      ticks(1);
      n++;
    end
    check("send_rdy", o_req_rdy, 1'b1);
    if (o_req_rdy) begin
      sb.push_back('{rs: rs, data: d});
      ticks(1);
    end
    i_req_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (o_busy && n < 300) begin
      ticks(1);
      n++;
    end
    check("drain_busy", o_busy, 1'b0);
    ticks(2);
  endtask

  function automatic int exp_delay(input item_t it);
    return (!it.rs && (it.data == 8'h01 || it.data == 8'h02 || it.data == 8'h03)) ? LD : CD;
  endfunction

  // Monitor: byte order, EN width and EN-fall to done latency for every item.
  item_t cur;
  logic  en_prev   = 1'b0;
  logic  done_prev = 1'b0;
  int    en_cnt    = 0;
  int    wcnt      = 0;
  int    phase     = 0;

  always @(negedge i_clk) begin
    if (!i_reset) begin
      en_prev   = 1'b0;
      done_prev = 1'b0;
      phase     = 0;
    end else begin
      check("zero_bits", {o_io_lcd[30:11], o_io_lcd[8]}, 32'h0);
      if (o_io_lcd[10] && !en_prev) begin
        check("sb_nonempty", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          check("sb_byte", o_io_lcd[9:0], {cur.rs, 1'b0, cur.data});
          en_cnt = 0;
          phase  = 1;
        end
      end
      if (o_io_lcd[10]) en_cnt++;
      if (!o_io_lcd[10] && en_prev && phase == 1) begin
        check("pulse_len", en_cnt, P);
        wcnt  = 0;
        phase = 2;
      end else if (phase == 2) begin
        wcnt++;
      end
      if (o_done) begin
        check("done_single", done_prev, 1'b0);
        check("done_phase", phase, 2);
        check("done_latency", wcnt, H + exp_delay(cur));
        phase = 0;
      end
      en_prev   = o_io_lcd[10];
      done_prev = o_done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_en;
    i_reset    = 1'b0;
    i_req_vld  = 1'b0;
    i_req_rs   = 1'b0;
    i_req_data = 8'h00;
    i_lcd_on   = 1'b0;
    #12;
    check("rst_lcd", o_io_lcd, 32'h0);
    check("rst_rdy", o_req_rdy, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    @(negedge i_clk);
    i_reset = 1'b1;
    ticks(1);
    check("rdy_after_rst", o_req_rdy, 1'b1);

    // single data write
    send(1'b1, 8'h41);
    check("busy_after_accept", o_busy, 1'b1);
    ticks(1);
    check("wr_bus_e1", o_io_lcd[10:0], 11'h241);
    ticks(1);
    check("wr_en_e2", o_io_lcd[10], 1'b0);
    ticks(1);
    check("wr_en_e3", o_io_lcd[10], 1'b1);
    ticks(2);
    check("wr_en_e5", o_io_lcd[10], 1'b1);
    ticks(1);
    check("wr_en_e6", o_io_lcd[10], 1'b0);
    ticks(5);
    check("wr_done_e11", o_done, 1'b0);
    ticks(1);
    check("wr_done_e12", o_done, 1'b1);
    ticks(1);
    check("wr_done_e13", o_done, 1'b0);
    check("wr_busy_e13", o_busy, 1'b0);
    check("wr_hold_e13", o_io_lcd[9:0], 10'h241);

    // clear command uses the long delay
    send(1'b0, 8'h01);
    ticks(3);
    check("clr_en_e3", o_io_lcd[10], 1'b1);
    ticks(3);
    check("clr_en_e6", o_io_lcd[10], 1'b0);
    ticks(20);
    check("clr_done_e26", o_done, 1'b0);
    ticks(1);
    check("clr_done_e27", o_done, 1'b1);
    ticks(2);

    // fill the FIFO while the FSM is busy
    send(1'b1, 8'h50);
    ticks(1);
    send(1'b1, 8'h51);
    send(1'b0, 8'h52);
    send(1'b1, 8'h53);
    check("fill_rdy_e4", o_req_rdy, 1'b1);
    send(1'b1, 8'h54);
    check("fill_rdy_e5", o_req_rdy, 1'b0);
    ticks(7);
    check("fill_rdy_e12", o_req_rdy, 1'b0);
    ticks(1);
    check("fill_rdy_e13", o_req_rdy, 1'b1);
    ticks(1);
    check("fill_en_e14", o_io_lcd[10], 1'b0);
    ticks(1);
    check("fill_en_e15", o_io_lcd[10], 1'b1);
    check("fill_bus_e15", o_io_lcd[9:0], 10'h251);
    drain();
    check("fill_sb_empty", sb.size(), 0);

    // ON passthrough during WAIT
    send(1'b1, 8'h30);
    ticks(8);
    i_lcd_on = 1'b1;
    #1;
    check("on_before_edge", o_io_lcd[31], 1'b0);
    ticks(1);
    check("on_rise", o_io_lcd[31], 1'b1);
    i_lcd_on = 1'b0;
    ticks(1);
    check("on_fall", o_io_lcd[31], 1'b0);
    drain();

    // reset in the middle of PULSE with items queued
    i_lcd_on = 1'b1;
    send(1'b1, 8'h61);
    send(1'b1, 8'h62);
    send(1'b1, 8'h63);
    ticks(2);
    check("mid_en_e4", o_io_lcd[10], 1'b1);
    i_reset = 1'b0;
    #1;
    check("mid_rst_lcd", o_io_lcd, 32'h0);
    check("mid_rst_rdy", o_req_rdy, 1'b0);
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_done", o_done, 1'b0);
    sb.delete();
    i_req_vld  = 1'b1;
    i_req_rs   = 1'b1;
    i_req_data = 8'h77;
    #10;
    @(negedge i_clk);
    i_reset = 1'b1;
    ticks(1);
    check("mid_rdy_first_edge", o_req_rdy, 1'b1);
    i_req_vld = 1'b0;
    saw_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ticks(1);
      saw_en = saw_en | o_io_lcd[10];
    end
    check("mid_no_en", saw_en, 1'b0);
    check("mid_busy", o_busy, 1'b0);
    check("mid_on", o_io_lcd[31], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
